// File: rtl/vx_fetch_sched.sv
// vx_fetch_sched: per-warp PC/mask/status with round-robin warp selection feeding decode.
// Warp spawn is compiled in only when VX_FETCH_WSPAWN_EN is defined.

module vx_fetch_warp #(
  parameter int          NT         = 4,
  parameter logic [31:0] RST_PC     = 32'h0,
  parameter bit          RST_ACTIVE = 1'b0
)(
  input  logic          gclk,
  input  logic          grst,
  input  logic          fetch,
  input  logic          stall,
  input  logic          chg_mask,
  input  logic [NT-1:0] new_mask,
  input  logic          halt,
  input  logic          spawn,
  input  logic [31:0]   spawn_pc,
  input  logic          jal,
  input  logic [31:0]   jal_dest,
  input  logic          br,
  input  logic          br_taken,
  input  logic [31:0]   br_dest,
  output logic [31:0]   pc,
  output logic [NT-1:0] mask,
  output logic          active,
  output logic          stalled
);
  localparam logic [NT-1:0] ONE = {{(NT-1){1'b0}}, 1'b1};

  always_ff @(posedge gclk) begin
    if (grst) begin
      pc      <= RST_PC;
      mask    <= RST_ACTIVE ? ONE : '0;
      active  <= RST_ACTIVE;
      stalled <= 1'b0;
    end else begin
      // resolution overrides the sequential increment; jal beats branch
      if (active && jal)                 pc <= jal_dest;
      else if (active && br && br_taken) pc <= br_dest;
      else if (fetch)                    pc <= pc + 32'd4;
      if (active && (jal || br)) stalled <= 1'b0;
      if (stall)                 stalled <= 1'b1;
      if (chg_mask) begin
        mask <= new_mask;
        if (new_mask == '0) active <= 1'b0;
      end
      if (halt) begin
        active  <= 1'b0;
        stalled <= 1'b0;
      end
      if (spawn && !active) begin
        active <= 1'b1;
        pc     <= spawn_pc;
        mask   <= ONE;
      end
    end
  end
endmodule

module vx_fetch_sched #(
  parameter int          NW       = 2,
  parameter int          NT       = 4,
  parameter logic [31:0] START_PC = 32'h80000000,
  localparam int         WW       = $clog2(NW)
)(
  input  logic          gclk,
  input  logic          grst,
  input  logic          in_freeze,
  input  logic          in_clone_stall,
  input  logic          in_branch_stall,
  input  logic          in_change_mask,
  input  logic [NT-1:0] in_thread_mask,
  input  logic          in_wspawn,
  input  logic [31:0]   in_wspawn_pc,
  input  logic          in_ebreak,
  input  logic          in_jal,
  input  logic [31:0]   in_jal_dest,
  input  logic [WW-1:0] in_jal_warp_num,
  input  logic          in_branch_valid,
  input  logic          in_branch_dir,
  input  logic [31:0]   in_branch_dest,
  input  logic [WW-1:0] in_branch_warp_num,
  output logic [31:0]   out_imem_addr,
  input  logic [31:0]   in_imem_data,
  output logic [31:0]   out_instruction,
  output logic [31:0]   out_curr_PC,
  output logic [NT-1:0] out_valid,
  output logic [WW-1:0] out_warp_num,
  output logic          out_busy
);
  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [NT-1:0] valid;
    logic [WW-1:0] wid;
  } fd_t;

  fd_t                  fd;
  logic [NW-1:0][31:0]  pc;
  logic [NW-1:0][NT-1:0] mask;
  logic [NW-1:0]        active, stalled, elig;
  logic [WW-1:0]        rr, sel, cand;
  logic                 found, frozen, dec_vld, spawn_en;

  assign frozen  = in_freeze | in_clone_stall;
  assign dec_vld = |fd.valid;

`ifdef VX_FETCH_WSPAWN_EN
  assign spawn_en = dec_vld & in_wspawn;
`else
  assign spawn_en = 1'b0;
  logic unused_spawn;
  assign unused_spawn = &{1'b0, in_wspawn, in_wspawn_pc};
`endif

  for (genvar w = 0; w < NW; w++) begin : g_warp
    logic hit;
    assign hit     = dec_vld && (fd.wid == WW'(w));
    // a control instruction sitting in decode blocks its own warp this cycle
    assign elig[w] = active[w] & ~stalled[w] & ~(in_branch_stall & hit);

    vx_fetch_warp #(
      .NT(NT), .RST_PC(w == 0 ? START_PC : 32'h0), .RST_ACTIVE(w == 0)
    ) u_warp (
      .gclk     (gclk),
      .grst     (grst),
      .fetch    (!frozen && found && (sel == WW'(w))),
      .stall    (hit && in_branch_stall),
      .chg_mask (hit && in_change_mask),
      .new_mask (in_thread_mask),
      .halt     (hit && in_ebreak),
      .spawn    (spawn_en && (w != 0)),
      .spawn_pc (in_wspawn_pc),
      .jal      (in_jal && (in_jal_warp_num == WW'(w))),
      .jal_dest (in_jal_dest),
      .br       (in_branch_valid && (in_branch_warp_num == WW'(w))),
      .br_taken (in_branch_dir),
      .br_dest  (in_branch_dest),
      .pc       (pc[w]),
      .mask     (mask[w]),
      .active   (active[w]),
      .stalled  (stalled[w])
    );
  end

  // first eligible warp after the round-robin pointer, wrapping
  always_comb begin
    sel   = rr;
    found = 1'b0;
    cand  = rr;
    for (int k = 0; k < NW; k++) begin
      cand = (cand == WW'(NW-1)) ? '0 : cand + 1'b1;
      if (!found && elig[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign out_imem_addr = pc[sel];

  always_ff @(posedge gclk) begin
    if (grst) begin
      fd <= '0;
      rr <= WW'(NW-1);
    end else if (!frozen) begin
      if (found) begin
        fd.instr <= in_imem_data;
        fd.pc    <= pc[sel];
        fd.valid <= mask[sel];
        fd.wid   <= sel;
        rr       <= sel;
      end else begin
        fd.instr <= '0;
        fd.valid <= '0;
      end
    end
  end

  assign out_instruction = fd.instr;
  assign out_curr_PC     = fd.pc;
  assign out_valid       = fd.valid;
  assign out_warp_num    = fd.wid;
  assign out_busy        = |active;
endmodule
